// File: rtl/bidir_pin_ctrl.sv
// rtl/bidir_pin_ctrl.sv - half-duplex write/read sequencer driving bidir_pin with turnaround and sync waits
// Optional feature: BIDIR_PARK_IN_EN returns the bus to input after every write.
module bidir_pin_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             dir,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in
);

  localparam int CW = $clog2(TURN_CYCLES + SYNC_STAGES + 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] TURN_IN_LD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, TURN_OUT, DRIVE, TURN_IN, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  assign wr_ready = (state_q == IDLE);
  assign busy     = !wr_ready;
  assign dir      = dir_q;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    sync_d[0] = data_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    dir_d      = dir_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        // Write wins arbitration; an already-driving bus skips turnaround.
        if (wr_valid) begin
          wdata_d = wr_data;
          if (dir_q) begin
            state_d = DRIVE;
            cnt_d   = ONE;
          end else begin
            state_d = TURN_OUT;
            cnt_d   = TURN_LD;
          end
        end else if (rd_req) begin
          dir_d = 1'b0;
          if (dir_q) begin
            state_d = TURN_IN;
            cnt_d   = TURN_IN_LD;
          end else begin
            state_d = SAMPLE;
            cnt_d   = SYNC_LD;
          end
        end
      end
      TURN_OUT: begin
        if (cnt_q == '0) begin
          dir_d      = 1'b1;
          data_out_d = wdata_q;
          state_d    = DRIVE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      DRIVE: begin
        dir_d      = 1'b1;
        data_out_d = wdata_q;
        if (cnt_q == '0) begin
`ifdef BIDIR_PARK_IN_EN
          dir_d   = 1'b0;
          state_d = TURN_IN;
          cnt_d   = TURN_IN_LD;
`else
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      TURN_IN: begin
        if (cnt_q == '0) begin
`ifdef BIDIR_PARK_IN_EN
          state_d = IDLE;
          cnt_d   = '0;
`else
          state_d = SAMPLE;
          cnt_d   = SYNC_LD;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          rd_data_d  = sync_q[SYNC_STAGES-1];
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      dir_q      <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      dir_q      <= dir_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

endmodule

// File: tb/tb_bidir_pin_ctrl.sv
// tb/tb_bidir_pin_ctrl.sv - directed self-checking bench for bidir_pin_ctrl
module tb_bidir_pin_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       dir;
  logic [7:0] data_out;
  logic [7:0] data_in;

  int total = 0;
  int bad   = 0;
  int pulses;

  bidir_pin_ctrl #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .dir      (dir),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0xA5 from dir=0 through turnaround
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    chk("w1_e0_busy", 32'(busy), 32'h1);
    chk("w1_e0_dir", 32'(dir), 32'h0);
    tick();
    chk("w1_e1_dir", 32'(dir), 32'h0);
    tick();
    chk("w1_e2_dir", 32'(dir), 32'h0);
    chk("w1_e2_data_out", 32'(data_out), 32'h00);
    tick();
    chk("w1_e3_dir", 32'(dir), 32'h1);
    chk("w1_e3_data_out", 32'(data_out), 32'hA5);
    chk("w1_e3_wr_ready", 32'(wr_ready), 32'h0);
    tick();
`ifdef BIDIR_PARK_IN_EN
    chk("park_e4_dir", 32'(dir), 32'h0);
    chk("park_e4_busy", 32'(busy), 32'h1);
    tick();
    chk("park_e5_busy", 32'(busy), 32'h1);
    tick();
    chk("park_e6_wr_ready", 32'(wr_ready), 32'h1);
    chk("park_e6_data_out", 32'(data_out), 32'hA5);
`else
    chk("w1_e4_wr_ready", 32'(wr_ready), 32'h1);
    chk("w1_e4_dir", 32'(dir), 32'h1);

    // back-to-back write with bus already driving
    wr_valid = 1'b1; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    chk("w2_e0_data_out", 32'(data_out), 32'hA5);
    chk("w2_e0_busy", 32'(busy), 32'h1);
    tick();
    chk("w2_e1_data_out", 32'(data_out), 32'h3C);
    chk("w2_e1_dir", 32'(dir), 32'h1);
    tick();
    chk("w2_e2_wr_ready", 32'(wr_ready), 32'h1);

    // read with dir=1: W = 4, rd_valid after E5
    data_in = 8'h5A; rd_req = 1'b1;
    tick();
    chk("r1_e0_dir", 32'(dir), 32'h0);
    chk("r1_e0_data_out", 32'(data_out), 32'h3C);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("r1_wait_rd_valid", 32'(rd_valid), 32'h0);
    end
    tick();
    chk("r1_e5_rd_valid", 32'(rd_valid), 32'h1);
    chk("r1_e5_rd_data", 32'(rd_data), 32'h5A);
    chk("r1_e5_wr_ready", 32'(wr_ready), 32'h1);
    rd_req = 1'b0;
    tick();
    chk("r1_e6_rd_valid", 32'(rd_valid), 32'h0);
`endif

    // simultaneous write and read: write first, exactly one rd_valid
    data_in = 8'h77; wr_valid = 1'b1; wr_data = 8'h11; rd_req = 1'b1;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_valid) begin
        pulses++;
        chk("arb_rd_data", 32'(rd_data), 32'h77);
        chk("arb_write_first", 32'(data_out), 32'h11);
        rd_req = 1'b0;
      end
    end
    chk("arb_pulse_count", 32'(pulses), 32'd1);
    chk("arb_final_dir", 32'(dir), 32'h0);
    chk("arb_final_data_out", 32'(data_out), 32'h11);

    // reset during TURN_OUT
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    tick();
    chk("abort_w_in_turn", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_w_dir", 32'(dir), 32'h0);
    chk("abort_w_data_out", 32'(data_out), 32'h00);
    chk("abort_w_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_w_post_dir", 32'(dir), 32'h0);
      chk("abort_w_post_data_out", 32'(data_out), 32'h00);
      chk("abort_w_post_rd_valid", 32'(rd_valid), 32'h0);
    end

    // reset during SAMPLE discards the pending read
    data_in = 8'hC3; rd_req = 1'b1;
    tick();
    tick();
    chk("abort_r_in_sample", 32'(busy), 32'h1);
    rst_n = 1'b0; rd_req = 1'b0;
    #1;
    chk("abort_r_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_r_rd_valid", 32'(rd_valid), 32'h0);
    end
    chk("abort_r_rd_data", 32'(rd_data), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
